// File: rtl/uart_program_loader_if.sv
// Loader bus: UART RX FIFO pop side plus instruction-memory write port and status.
// master = loader, slave = FIFO/memory/datapath environment.
interface uart_program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            uartFifoDataIn;
    logic                  uartDataAvailable;
    logic                  readFlag;
    logic                  instrWriteEnable;
    logic [ADDR_WIDTH-1:0] instrWriteAddr;
    logic [31:0]           instrWriteData;
    logic                  holdDatapath;
    logic                  loadDone;
    logic                  checksumError;

    modport master (
        input  uartFifoDataIn, uartDataAvailable,
        output readFlag, instrWriteEnable, instrWriteAddr, instrWriteData,
        output holdDatapath, loadDone, checksumError
    );

    modport slave (
        output uartFifoDataIn, uartDataAvailable,
        input  readFlag, instrWriteEnable, instrWriteAddr, instrWriteData,
        input  holdDatapath, loadDone, checksumError
    );
endinterface

// File: rtl/uart_program_loader.sv
// Loads a START/COUNT/words/XOR-check framed program image from the UART FIFO
// into instruction memory, holding the datapath in reset until a good load.
module uart_program_loader #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] START_CMD  = 8'h4C
) (
    input  logic                clk,
    input  logic                reset,
    uart_program_loader_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, GET_COUNT, GET_BYTES, WRITE, GET_CHECK, DONE, ERROR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic                  skip_q, skip_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]           word_q, word_d;
    logic [1:0]            idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  receiving;
    logic                  pop;
    logic [7:0]            rx_byte;

    // skip_q blocks the cycle after a pop while the FIFO head updates;
    // reset gating keeps the pop strobe quiet while the block is held in reset
    assign receiving = (state_q == IDLE) || (state_q == GET_COUNT) ||
                       (state_q == GET_BYTES) || (state_q == GET_CHECK);
    assign pop       = receiving && bus.uartDataAvailable && !skip_q && reset;
    assign rx_byte   = bus.uartFifoDataIn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            skip_q  <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = pop;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (pop && rx_byte == START_CMD) begin
                    state_d = GET_COUNT;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    addr_d  = '0;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            GET_COUNT: begin
                if (pop) begin
                    cnt_d   = ADDR_WIDTH'(rx_byte);
                    state_d = GET_BYTES;
                end
            end
            GET_BYTES: begin
                if (pop) begin
                    word_d = {word_q[23:0], rx_byte};
                    csum_d = csum_q ^ rx_byte;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = WRITE;
                end
            end
            WRITE: begin
                // a loaded count of zero wraps through all 2^ADDR_WIDTH words
                addr_d  = addr_q + ONE;
                cnt_d   = cnt_q - ONE;
                state_d = (cnt_q == ONE) ? GET_CHECK : GET_BYTES;
            end
            GET_CHECK: begin
                if (pop) begin
                    if (rx_byte == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.readFlag         = pop;
    assign bus.instrWriteEnable = (state_q == WRITE);
    assign bus.instrWriteAddr   = addr_q;
    assign bus.instrWriteData   = word_q;
    assign bus.holdDatapath     = hold_q;
    assign bus.loadDone         = done_q;
    assign bus.checksumError    = err_q;
endmodule
